fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//  Reader-side drain engine for an async_fifo read port, in the read clock domain.
//  Issues rinc against rempty and absorbs the FIFO's read latency:
//  0 cycles with FALLTHROUGH="TRUE", 1 cycle with "FALSE".
//  Presents the words as a valid/ready stream with full throughput and backpressure.
//  Adds a handshake counter and a flush (drain-and-discard) sequence.
// PARAMETERS
//  DSIZE        8       data width; must match the FIFO DSIZE
//  FALLTHROUGH  "TRUE"  FIFO read mode: "TRUE" = rdata valid while !rempty; "FALSE" = rdata valid 1 cycle after rinc
//  CNT_W        16      width of rd_count
// PORTS
//  rclk        in   1        clock (FIFO read clock)
//  rrst        in   1        synchronous reset, active-high
//  rinc        out  1        FIFO read increment
//  rdata       in   DSIZE    FIFO read data
//  rempty      in   1        FIFO empty flag
//  m_valid     out  1        stream data valid
//  m_ready     in   1        stream consumer ready
//  m_data      out  DSIZE    stream data
//  flush       in   1        level; request drain-and-discard of FIFO and buffer
//  flush_done  out  1        1-cycle pulse when the flush completes
//  rd_count    out  CNT_W    count of accepted stream words
// BEHAVIOUR
//  Reset (rrst=1 at a rclk edge) forces:
//   - rinc=0, m_valid=0, m_data=0, flush_done=0, rd_count=0
//   - occ=0, inflight=0, state=RUN
//   - takes effect regardless of state; in-flight read data is discarded.
//  Output buffer:
//   - 2-entry FIFO; occ in 0..2; m_valid = (occ!=0); m_data = head entry.
//   - Head is stable while m_valid && !m_ready.
//   - pop = m_valid && m_ready.
//  inflight (FALLTHROUGH="FALSE" only; tied 0 for "TRUE"):
//   - set on the cycle after rinc=1; cleared on the capture cycle.
//  Space rule (combinational; m_ready->rinc path is allowed):
//   - space = (occ + inflight - pop) < 2
//  RUN state:
//   - rinc = !rempty && space.
//   - "TRUE": rdata is pushed at the same edge as rinc; m_valid rises the next cycle.
//   - "FALSE": rinc at cycle t; rdata is captured at the t+1 edge; m_valid rises at t+2.
//   - Steady state with m_ready=1: one word per cycle in both modes.
//   - Push and pop in the same cycle: occ is unchanged and order is preserved.
//   - occ never exceeds 2; words are never lost or duplicated.
//  Counter:
//   - rd_count += 1 on each pop; wraps modulo 2^CNT_W.
//  States:
//   - RUN -> FLUSH when flush=1.
//   - FLUSH:
//     - m_valid forced 0 from the next cycle; occ cleared; pops are not counted.
//     - rinc = !rempty; read data and in-flight captures are discarded.
//     - FLUSH -> RUN when rempty=1 && inflight=0; flush_done=1 for that one cycle.
//     - flush held high after completion: stays in RUN, and a new flush starts only after flush drops.
//  Flush asserted while rempty=1 and nothing is buffered: flush_done pulses the next cycle.
// TESTING
//  1. TRUE, FIFO holds 11,22,33, m_ready=1 -> m_data 11,22,33 on consecutive cycles; rd_count=3.
//  2. FALSE, same data -> first rinc at t, m_valid at t+2, then 1 word/cycle; no gaps.
//  3. m_ready=0 after word 11, 4 words available -> rinc stops at occ=2; m_data holds 11; release gives 22,33,44 in order.
//  4. Flush with 5 words in FIFO and occ=2 -> m_valid=0 next cycle; rinc until rempty; one flush_done pulse; rd_count unchanged.
//  5. rrst=1 mid-stream with inflight=1 (FALSE) -> all outputs 0 next cycle; captured word discarded.
//  6. CNT_W=4, 17 words streamed -> rd_count wraps to 0 after 16 words, then reads 1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains an async FIFO read port into a valid/ready stream.
// Hides the FIFO read latency (0 or 1 cycle) behind a 2-entry skid buffer so
// the stream runs at one word per cycle and still honours backpressure.
// Also counts accepted words and supports a drain-and-discard flush.
module fifo_rd_stream #(
   parameter int    DSIZE       = 8,
   parameter string FALLTHROUGH = "TRUE",
   parameter int    CNT_W       = 16
) (
   input  logic             rclk,
   input  logic             rrst,
   output logic             rinc,
   input  logic [DSIZE-1:0] rdata,
   input  logic             rempty,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [DSIZE-1:0] m_data,
   input  logic             flush,
   output logic             flush_done,
   output logic [CNT_W-1:0] rd_count
);

   // Fallthrough FIFOs present rdata combinationally; registered ones one cycle after rinc.
   localparam bit FT = (FALLTHROUGH == "TRUE");

   typedef enum logic {RUN, FLUSH} state_t;

   state_t                    state_q, state_d;
   logic [1:0]                occ_q;        // skid buffer occupancy, 0..2
   logic [1:0][DSIZE-1:0]     buf_q;        // [0] is the head
   logic                      inflight_q;   // a registered-mode read is on its way
   logic                      flush_blk_q;  // flush finished but request still held
   logic                      inflight;
   logic                      pop;
   logic                      push;
   logic                      space;
   logic [2:0]                fill;

   assign inflight = FT ? 1'b0 : inflight_q;
   assign m_valid  = (occ_q != 2'd0);
   assign m_data   = buf_q[0];
   assign pop      = m_valid && m_ready;

   // Words already committed to the buffer, minus the one leaving this cycle.
   assign fill  = {1'b0, occ_q} + {2'b00, inflight} - {2'b00, pop};
   assign space = (fill < 3'd2);

   // Data lands in the buffer on the rinc edge (fallthrough) or one edge later.
   assign push = (state_q == RUN) && (FT ? rinc : inflight_q);

   // Next state, FIFO read strobe and flush completion pulse.
   always_comb begin
      state_d    = state_q;
      rinc       = 1'b0;
      flush_done = 1'b0;
      case (state_q)
         RUN: begin
            rinc = !rempty && space;
            if (flush && !flush_blk_q) state_d = FLUSH;
         end
         FLUSH: begin
            rinc = !rempty;
            if (rempty && !inflight) begin
               flush_done = 1'b1;
               state_d    = RUN;
            end
         end
         default: state_d = RUN;
      endcase
      if (rrst) begin
         rinc       = 1'b0;
         flush_done = 1'b0;
      end
   end

   // State, read tracking, skid buffer and handshake counter.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         state_q     <= RUN;
         occ_q       <= 2'd0;
         buf_q       <= '0;
         inflight_q  <= 1'b0;
         flush_blk_q <= 1'b0;
         rd_count    <= '0;
      end else begin
         state_q     <= state_d;
         inflight_q  <= FT ? 1'b0 : rinc;
         // Re-arm only once the flush request has been released.
         flush_blk_q <= flush && (flush_blk_q || flush_done);
         if (pop) rd_count <= rd_count + CNT_W'(1);

         if (state_q == RUN && state_d == FLUSH) begin
            occ_q <= 2'd0;
         end else begin
            case ({push, pop})
               2'b10: begin
                  if (occ_q == 2'd0) buf_q[0] <= rdata;
                  else               buf_q[1] <= rdata;
                  occ_q <= occ_q + 2'd1;
               end
               2'b01: begin
                  buf_q[0] <= buf_q[1];
                  occ_q    <= occ_q - 2'd1;
               end
               2'b11: begin
                  // Occupancy unchanged; new word goes behind whatever remains.
                  if (occ_q == 2'd1) begin
                     buf_q[0] <= rdata;
                  end else begin
                     buf_q[0] <= buf_q[1];
                     buf_q[1] <= rdata;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: one fallthrough instance (4-bit counter) and one
// registered-read instance, each fed by a small behavioural FIFO model.
module tb_fifo_rd_stream;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // fallthrough instance
   logic       t_rinc, t_rempty, t_mvalid, t_mready, t_flush, t_done;
   logic [7:0] t_rdata, t_mdata;
   logic [3:0] t_cnt;
   logic [7:0] t_mem [64];
   logic [5:0] t_wp = 6'd0;
   logic [5:0] t_rp;
   logic [7:0] t_exp [$];

   // registered-read instance
   logic        f_rinc, f_rempty, f_mvalid, f_mready, f_flush, f_done;
   logic [7:0]  f_rdata, f_mdata;
   logic [15:0] f_cnt;
   logic [7:0]  f_mem [64];
   logic [5:0]  f_wp = 6'd0;
   logic [5:0]  f_rp;
   logic [7:0]  f_exp [$];

   assign t_rempty = (t_wp == t_rp);
   assign t_rdata  = t_mem[t_rp];
   assign f_rempty = (f_wp == f_rp);

   // FIFO models: reset empties them, rinc advances the read pointer.
   always @(posedge clk) begin
      if (rst) t_rp <= t_wp;
      else if (t_rinc) t_rp <= t_rp + 6'd1;
   end

   always @(posedge clk) begin
      if (rst) f_rp <= f_wp;
      else if (f_rinc) begin
         f_rdata <= f_mem[f_rp];
         f_rp    <= f_rp + 6'd1;
      end
   end

   fifo_rd_stream #(.DSIZE(8), .FALLTHROUGH("TRUE"), .CNT_W(4)) u_t (
      .rclk(clk), .rrst(rst), .rinc(t_rinc), .rdata(t_rdata), .rempty(t_rempty),
      .m_valid(t_mvalid), .m_ready(t_mready), .m_data(t_mdata),
      .flush(t_flush), .flush_done(t_done), .rd_count(t_cnt));

   fifo_rd_stream #(.DSIZE(8), .FALLTHROUGH("FALSE"), .CNT_W(16)) u_f (
      .rclk(clk), .rrst(rst), .rinc(f_rinc), .rdata(f_rdata), .rempty(f_rempty),
      .m_valid(f_mvalid), .m_ready(f_mready), .m_data(f_mdata),
      .flush(f_flush), .flush_done(f_done), .rd_count(f_cnt));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic t_load(input logic [7:0] d, input bit expect_out);
      t_mem[t_wp] = d;
      t_wp = t_wp + 6'd1;
      if (expect_out) t_exp.push_back(d);
   endtask

   task automatic f_load(input logic [7:0] d, input bit expect_out);
      f_mem[f_wp] = d;
      f_wp = f_wp + 6'd1;
      if (expect_out) f_exp.push_back(d);
   endtask

   // Scoreboard monitors: every accepted word must be the next expected one.
   always @(negedge clk) begin
      logic [7:0] e;
      if (!rst && t_mvalid && t_mready) begin
         tests++;
         if (t_exp.size() == 0) begin
            fails++;
            $display("FAIL t_stream: got %0h, expected no word", t_mdata);
         end else begin
            e = t_exp.pop_front();
            if (t_mdata !== e) begin
               fails++;
               $display("FAIL t_stream: got %0h, expected %0h", t_mdata, e);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0] e;
      if (!rst && f_mvalid && f_mready) begin
         tests++;
         if (f_exp.size() == 0) begin
            fails++;
            $display("FAIL f_stream: got %0h, expected no word", f_mdata);
         end else begin
            e = f_exp.pop_front();
            if (f_mdata !== e) begin
               fails++;
               $display("FAIL f_stream: got %0h, expected %0h", f_mdata, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone, nval, n;
      bit c16;
      t_mready = 1'b0; f_mready = 1'b0; t_flush = 1'b0; f_flush = 1'b0;

      // reset state
      repeat (3) cyc();
      smp();
      chk("rst_t_valid", 32'(t_mvalid), 32'd0);
      chk("rst_t_data",  32'(t_mdata),  32'd0);
      chk("rst_t_cnt",   32'(t_cnt),    32'd0);
      chk("rst_t_rinc",  32'(t_rinc),   32'd0);
      chk("rst_t_done",  32'(t_done),   32'd0);
      chk("rst_f_valid", 32'(f_mvalid), 32'd0);
      chk("rst_f_data",  32'(f_mdata),  32'd0);
      chk("rst_f_cnt",   32'(f_cnt),    32'd0);
      cyc(); rst = 1'b0;

      // 1: fallthrough, three words back to back
      cyc(); t_mready = 1'b1;
      t_load(8'h11, 1'b1); t_load(8'h22, 1'b1); t_load(8'h33, 1'b1);
      smp(); chk("t1_rinc", 32'(t_rinc), 32'd1); chk("t1_valid0", 32'(t_mvalid), 32'd0);
      cyc(); smp(); chk("t1_w0", 32'({t_mvalid, t_mdata}), 32'h111);
      cyc(); smp(); chk("t1_w1", 32'({t_mvalid, t_mdata}), 32'h122);
      cyc(); smp(); chk("t1_w2", 32'({t_mvalid, t_mdata}), 32'h133);
      cyc(); smp(); chk("t1_idle", 32'(t_mvalid), 32'd0); chk("t1_cnt", 32'(t_cnt), 32'd3);

      // 2: registered read, m_valid two cycles after first rinc, then no gaps
      cyc(); f_mready = 1'b1;
      f_load(8'h11, 1'b1); f_load(8'h22, 1'b1); f_load(8'h33, 1'b1);
      smp(); chk("t2_rinc", 32'(f_rinc), 32'd1); chk("t2_v_t0", 32'(f_mvalid), 32'd0);
      cyc(); smp(); chk("t2_v_t1", 32'(f_mvalid), 32'd0);
      cyc(); smp(); chk("t2_w0", 32'({f_mvalid, f_mdata}), 32'h111);
      cyc(); smp(); chk("t2_w1", 32'({f_mvalid, f_mdata}), 32'h122);
      cyc(); smp(); chk("t2_w2", 32'({f_mvalid, f_mdata}), 32'h133);
      cyc(); smp(); chk("t2_idle", 32'(f_mvalid), 32'd0); chk("t2_cnt", 32'(f_cnt), 32'd3);

      // 3: backpressure after the first word
      cyc(); t_mready = 1'b0;
      t_load(8'h11, 1'b1); t_load(8'h22, 1'b1); t_load(8'h33, 1'b1); t_load(8'h44, 1'b1);
      cyc(); smp(); chk("t3_head", 32'({t_mvalid, t_mdata}), 32'h111);
      cyc(); smp(); chk("t3_rinc_stop", 32'(t_rinc), 32'd0);
      repeat (3) cyc();
      smp(); chk("t3_hold", 32'({t_mvalid, t_mdata}), 32'h111); chk("t3_rinc_held", 32'(t_rinc), 32'd0);
      cyc(); t_mready = 1'b1;
      smp(); chk("t3_r0", 32'(t_mdata), 32'h11);
      cyc(); smp(); chk("t3_r1", 32'(t_mdata), 32'h22);
      cyc(); smp(); chk("t3_r2", 32'(t_mdata), 32'h33);
      cyc(); smp(); chk("t3_r3", 32'(t_mdata), 32'h44);
      cyc(); smp(); chk("t3_idle", 32'(t_mvalid), 32'd0); chk("t3_cnt", 32'(t_cnt), 32'd7);

      // 4: flush with buffer full and five words left in the FIFO
      cyc(); t_mready = 1'b0;
      for (int i = 0; i < 7; i++) t_load(8'(8'hA0 + i), 1'b0);
      repeat (3) cyc();
      smp(); chk("t4_full", 32'({t_mvalid, t_mdata}), 32'h1A0); chk("t4_rinc0", 32'(t_rinc), 32'd0);
      cyc(); t_flush = 1'b1;
      smp(); chk("t4_valid_c", 32'(t_mvalid), 32'd1);
      ndone = 0; nval = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(); smp();
         if (i == 0) chk("t4_valid_drop", 32'(t_mvalid), 32'd0);
         if (t_done) ndone++;
         if (t_mvalid) nval++;
      end
      chk("t4_done_pulses", 32'(ndone), 32'd1);
      chk("t4_no_valid", 32'(nval), 32'd0);
      chk("t4_fifo_empty", 32'(t_rempty), 32'd1);
      chk("t4_cnt", 32'(t_cnt), 32'd7);
      // flush still held: back in RUN, streaming normally
      cyc(); t_mready = 1'b1; t_load(8'h55, 1'b1);
      smp(); chk("t4_run_rinc", 32'(t_rinc), 32'd1);
      cyc(); smp(); chk("t4_run_w", 32'({t_mvalid, t_mdata}), 32'h155); chk("t4_no_reflush", 32'(t_done), 32'd0);
      cyc(); t_flush = 1'b0;
      smp(); chk("t4_cnt2", 32'(t_cnt), 32'd8);

      // 4b: flush with nothing to drain
      cyc(); t_flush = 1'b1;
      smp(); chk("t4b_done_c", 32'(t_done), 32'd0);
      cyc(); smp(); chk("t4b_done_c1", 32'(t_done), 32'd1);
      cyc(); t_flush = 1'b0;
      smp(); chk("t4b_done_c2", 32'(t_done), 32'd0);

      // 5: reset while a registered read is in flight
      cyc(); f_mready = 1'b0;
      f_load(8'hB0, 1'b0); f_load(8'hB1, 1'b0); f_load(8'hB2, 1'b0);
      smp(); chk("t5_rinc", 32'(f_rinc), 32'd1);
      cyc(); rst = 1'b1;
      smp(); chk("t5_rinc_rst", 32'(f_rinc), 32'd0);
      cyc(); smp();
      chk("t5_valid", 32'(f_mvalid), 32'd0); chk("t5_data", 32'(f_mdata), 32'd0);
      chk("t5_cnt", 32'(f_cnt), 32'd0); chk("t5_done", 32'(f_done), 32'd0);
      chk("t5_t_cnt", 32'(t_cnt), 32'd0);
      cyc(); rst = 1'b0; f_mready = 1'b1;
      repeat (3) cyc();
      smp(); chk("t5_discard", 32'(f_mvalid), 32'd0); chk("t5_cnt2", 32'(f_cnt), 32'd0);

      // 6: 4-bit counter wraps after 16 words
      cyc();
      for (int i = 0; i < 17; i++) t_load(8'(8'h60 + i), 1'b1);
      n = 0; c16 = 1'b0;
      for (int i = 0; i < 40 && n < 17; i++) begin
         smp();
         if (n == 16 && !c16) begin
            chk("t6_wrap0", 32'(t_cnt), 32'd0);
            c16 = 1'b1;
         end
         if (t_mvalid && t_mready) n++;
         cyc();
      end
      chk("t6_words", 32'(n), 32'd17);
      chk("t6_wrap_seen", 32'(c16), 32'd1);
      smp(); chk("t6_cnt1", 32'(t_cnt), 32'd1);

      repeat (3) cyc();
      chk("t_exp_left", 32'(t_exp.size()), 32'd0);
      chk("f_exp_left", 32'(f_exp.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
